fifo_rd_adapter: RTL and testbench



---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_rd_skid_buf.sv | 49 ++++
 rtl/fifo_rd_adapter.sv | 75 +++++++
 tb/tb_fifo_rd_adapter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: word width, word type and default skid depth,
// common to the FIFO, its interface and the read-side adapter.
package fifo_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int BUF_DEPTH_DEF = 3;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer with push/pop, occupancy count and head data.
// Storage is cleared on reset, so the head word reads 0 out of reset.
module fifo_rd_skid_buf import fifo_pkg::*; #(
    parameter int  BUF_DEPTH = BUF_DEPTH_DEF,
    parameter type T         = data_t
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_push,
    input  T                                   i_data,
    input  logic                               i_pop,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     o_count,
    output T                                   o_data
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH+1);
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH-1);

    T              r_mem [BUF_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            // push and pop together leave occupancy unchanged
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream via a skid buffer.
// Optional FIFO_RD_ADAPTER_STATS_EN adds word_cnt (wrapping) and stall_cnt (saturating).
module fifo_rd_adapter #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = fifo_pkg::BUF_DEPTH_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drain_en,
    output logic                  rd_en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

    localparam int CW = $clog2(BUF_DEPTH+1);

    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          r_rd_pend;

    // Reserve a slot for every read in flight so a returning word always fits;
    // m_ready is deliberately kept out of this path.
    assign rd_en = drain_en && !empty && !rst
                   && ((int'(w_count) + int'(r_rd_pend)) < BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) r_rd_pend <= 1'b0;
        else     r_rd_pend <= rd_en;
    end

    assign m_valid = (w_count != '0);
    assign w_pop   = m_valid && m_ready;

    fifo_rd_skid_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .T         (logic [DATA_WIDTH-1:0])
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_pend),
        .i_data  (data_out),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_data  (m_data)
    );

`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
            if (m_valid && !m_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign word_cnt  = r_word_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_adapter;

    localparam int BD = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       drain_en = 1'b0;
    logic       m_ready  = 1'b0;
    logic       rd_en;
    logic       empty;
    logic       m_valid;
    logic [7:0] data_out = 8'h00;
    logic [7:0] m_data;
`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [31:0] word_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_rd_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(BD), .CNT_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .drain_en (drain_en),
        .rd_en    (rd_en),
        .empty    (empty),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef FIFO_RD_ADAPTER_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // behavioural FIFO: flushed by the shared rst, data one cycle after rd_en
    logic [7:0] fmem [0:4095];
    int wr_idx = 0;
    int rd_idx = 0;
    assign empty = (wr_idx == rd_idx);

    always @(posedge clk) begin
        if (rst) rd_idx <= wr_idx;
        else if (rd_en) begin
            data_out <= fmem[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    // monitors: accepted beats, read pulses, protocol violations
    logic [7:0] acc [0:4095];
    int acc_n     = 0;
    int rd_pulses = 0;
    bit bad_rd    = 1'b0;
    bit bad_cnt   = 1'b0;

    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) begin
            acc[acc_n] <= m_data;
            acc_n      <= acc_n + 1;
        end
        if (rd_en) rd_pulses <= rd_pulses + 1;
        if (rd_en && empty) bad_rd <= 1'b1;
        if (int'(dut.w_count) > BD) bad_cnt <= 1'b1;
    end

    task automatic push(input logic [7:0] v);
        fmem[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic hold_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; drain_en = 1'b1; m_ready = 1'b1;
        push(8'hEE);
        #1;
        checks++;
        if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        checks++;
        if (dut.w_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.w_count); end
        drain_en = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_burst;
        hold_reset();
        m_ready = 1'b1; drain_en = 1'b1; rst = 1'b0;
        for (int k = 1; k <= 16; k++) push(8'(k));
        #1;
        checks++;
        if (rd_en !== 1'b1) begin failures++; $display("FAIL burst_first_rd got=%0b exp=1", rd_en); end
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL burst_lat0 got=%0b exp=0", m_valid); end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL burst_lat1 got=%0b exp=0", m_valid); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(k)) begin
                failures++;
                $display("FAIL burst_beat%0d got v=%0b d=%h exp v=1 d=%h", k, m_valid, m_data, 8'(k));
            end
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || rd_en !== 1'b0) begin
            failures++; $display("FAIL burst_end got v=%0b rd=%0b exp 0 0", m_valid, rd_en);
        end
    endtask

    task automatic test_backpressure;
        int p0, base;
        hold_reset();
        m_ready = 1'b0; drain_en = 1'b1; rst = 1'b0;
        p0 = rd_pulses;
        for (int k = 0; k < 8; k++) push(8'hA0 + 8'(k));
        repeat (8) @(negedge clk);
        checks++;
        if (rd_pulses - p0 != 3) begin failures++; $display("FAIL bp_rd_pulses got=%0d exp=3", rd_pulses - p0); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
            failures++; $display("FAIL bp_head got v=%0b d=%h exp v=1 d=a0", m_valid, m_data);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (m_data !== 8'hA0) begin failures++; $display("FAIL bp_hold got=%h exp=a0", m_data); end
        base = acc_n;
        m_ready = 1'b1;
        repeat (14) @(negedge clk);
        checks++;
        if (acc_n - base != 8) begin failures++; $display("FAIL bp_beats got=%0d exp=8", acc_n - base); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (acc[base+k] !== 8'hA0 + 8'(k)) begin
                failures++; $display("FAIL bp_order%0d got=%h exp=%h", k, acc[base+k], 8'hA0 + 8'(k));
            end
        end
    endtask

    task automatic test_random;
        int base, pushed, cyc, errs;
        hold_reset();
        drain_en = 1'b1; rst = 1'b0;
        base = acc_n; pushed = 0; cyc = 0; errs = 0;
        while ((acc_n - base) < 1000 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push(8'(pushed * 37 + 5));
                pushed++;
            end
            m_ready = ($urandom_range(0, 1) == 1);
        end
        m_ready = 1'b0;
        checks++;
        if (acc_n - base != 1000) begin failures++; $display("FAIL rand_count got=%0d exp=1000", acc_n - base); end
        for (int k = 0; k < 1000; k++)
            if (acc[base+k] !== 8'(k * 37 + 5)) errs++;
        checks++;
        if (errs != 0) begin failures++; $display("FAIL rand_order bad_words=%0d exp=0", errs); end
        checks++;
        if (bad_cnt !== 1'b0) begin failures++; $display("FAIL rand_count_bound got=%0b exp=0", bad_cnt); end
        checks++;
        if (bad_rd !== 1'b0) begin failures++; $display("FAIL rand_rd_while_empty got=%0b exp=0", bad_rd); end
    endtask

    task automatic test_drain_pause;
        int p0, base;
        hold_reset();
        m_ready = 1'b1; drain_en = 1'b1; rst = 1'b0;
        p0 = rd_pulses; base = acc_n;
        for (int k = 0; k < 4; k++) push(8'h51 + 8'(k));
        #1;
        checks++;
        if (rd_en !== 1'b1) begin failures++; $display("FAIL pause_first_rd got=%0b exp=1", rd_en); end
        @(negedge clk);
        drain_en = 1'b0;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin failures++; $display("FAIL pause_rd_off got=%0b exp=0", rd_en); end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h51) begin
            failures++; $display("FAIL pause_inflight got v=%0b d=%h exp v=1 d=51", m_valid, m_data);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_pulses - p0 != 1 || m_valid !== 1'b0) begin
            failures++; $display("FAIL pause_idle got pulses=%0d v=%0b exp pulses=1 v=0", rd_pulses - p0, m_valid);
        end
        drain_en = 1'b1;
        #1;
        checks++;
        if (rd_en !== 1'b1) begin failures++; $display("FAIL pause_resume got=%0b exp=1", rd_en); end
        repeat (8) @(negedge clk);
        checks++;
        if (acc_n - base != 4) begin failures++; $display("FAIL pause_beats got=%0d exp=4", acc_n - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (acc[base+k] !== 8'h51 + 8'(k)) begin
                failures++; $display("FAIL pause_order%0d got=%h exp=%h", k, acc[base+k], 8'h51 + 8'(k));
            end
        end
    endtask

    task automatic test_mid_reset;
        int base;
        hold_reset();
        m_ready = 1'b0; drain_en = 1'b1; rst = 1'b0;
        for (int k = 0; k < 4; k++) push(8'h61 + 8'(k));
        repeat (3) @(negedge clk);
        checks++;
        if (dut.w_count !== 2'd2) begin failures++; $display("FAIL mrst_pre_count got=%0d exp=2", dut.w_count); end
        rst = 1'b1;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin failures++; $display("FAIL mrst_rd_en got=%0b exp=0", rd_en); end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || dut.w_count !== '0) begin
            failures++; $display("FAIL mrst_clear got v=%0b cnt=%0d exp v=0 cnt=0", m_valid, dut.w_count);
        end
        base = acc_n;
        rst = 1'b0; m_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (acc_n != base || m_valid !== 1'b0) begin
            failures++; $display("FAIL mrst_orphan got beats=%0d v=%0b exp beats=0 v=0", acc_n - base, m_valid);
        end
    endtask

`ifdef FIFO_RD_ADAPTER_STATS_EN
    task automatic test_stats;
        hold_reset();
        m_ready = 1'b0; drain_en = 1'b1; rst = 1'b0;
        for (int k = 0; k < 5; k++) push(8'h71 + 8'(k));
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin failures++; $display("FAIL stats_valid got=%0b exp=1", m_valid); end
        repeat (3) @(negedge clk);
        m_ready = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (word_cnt !== 32'd5) begin failures++; $display("FAIL stats_words got=%0d exp=5", word_cnt); end
        checks++;
        if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stats_stalls got=%0d exp=3", stall_cnt); end
        hold_reset();
        checks++;
        if (word_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            failures++; $display("FAIL stats_reset got w=%0d s=%0d exp 0 0", word_cnt, stall_cnt);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_drain_pause();
        test_mid_reset();
        test_random();
`ifdef FIFO_RD_ADAPTER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
